// File: rtl/fila_pkg.sv
// Shared constants and write-side state encoding for the fila_bytes byte queue.
package fila_pkg;
  localparam int FILA_WIDTH = 8;
  localparam int FILA_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } fila_state_t;
endpackage

// File: rtl/fila_mem.sv
// DEPTH x WIDTH register array: synchronous write port, combinational read port, no reset.
module fila_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];
endmodule

// File: rtl/fila_bytes.sv
// Byte FIFO behind the deserializador: ack handshake on the write side, pop-on-request read side.
// Optional sticky underflow flag err_out when FILA_ERR_EN is defined.
module fila_bytes
  import fila_pkg::*;
#(
  parameter int WIDTH = FILA_WIDTH,
  parameter int DEPTH = FILA_DEPTH
) (
  input  logic                   clk_100KHz,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   data_ready_in,
  output logic                   ack_out,
  input  logic                   dequeue_in,
  output logic [WIDTH-1:0]       data_out,
  output logic [$clog2(DEPTH):0] len_out,
  output logic                   full_out,
  output logic                   empty_out
`ifdef FILA_ERR_EN
  ,
  output logic                   err_out
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);

  fila_state_t      r_state;
  fila_state_t      w_state_nxt;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_len;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_rdata;
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;
  logic             w_ack;

  assign w_full  = (r_len == LEN_FULL);
  assign w_empty = (r_len == '0);
  assign w_rd    = dequeue_in && !w_empty;

  // WAIT_LOW keeps a data_ready held across the ack from being captured twice.
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      IDLE: begin
        if (data_ready_in && !w_full) begin
          w_wr        = 1'b1;
          w_state_nxt = ACK;
        end
      end
      ACK: begin
        w_ack       = 1'b1;
        w_state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!data_ready_in) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_len  <= '0;
      r_data <= '0;
    end else begin
      if (w_wr) r_tail <= r_tail + AW'(1);
      if (w_rd) begin
        r_head <= r_head + AW'(1);
        r_data <= w_rdata;
      end
      r_len <= r_len + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
    end
  end

  fila_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk_100KHz),
    .we   (w_wr),
    .waddr(r_tail),
    .wdata(data_in),
    .raddr(r_head),
    .rdata(w_rdata)
  );

`ifdef FILA_ERR_EN
  logic r_err;

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset)                     r_err <= 1'b0;
    else if (dequeue_in && w_empty) r_err <= 1'b1;
  end

  assign err_out = r_err;
`endif

  assign ack_out   = w_ack;
  assign data_out  = r_data;
  assign len_out   = r_len;
  assign full_out  = w_full;
  assign empty_out = w_empty;
endmodule

// File: tb/tb_fila_bytes.sv
// Directed bench for fila_bytes: table-driven handshake vectors plus hand-written fill/wrap/reset sequences.
module tb_fila_bytes;
  logic       clk_100KHz;
  logic       reset;
  logic [7:0] data_in;
  logic       data_ready_in;
  logic       ack_out;
  logic       dequeue_in;
  logic [7:0] data_out;
  logic [3:0] len_out;
  logic       full_out;
  logic       empty_out;
`ifdef FILA_ERR_EN
  logic       err_out;
`endif

  int total = 0;
  int bad   = 0;

  fila_bytes #(.WIDTH(8), .DEPTH(8)) dut (
    .clk_100KHz   (clk_100KHz),
    .reset        (reset),
    .data_in      (data_in),
    .data_ready_in(data_ready_in),
    .ack_out      (ack_out),
    .dequeue_in   (dequeue_in),
    .data_out     (data_out),
    .len_out      (len_out),
    .full_out     (full_out),
    .empty_out    (empty_out)
`ifdef FILA_ERR_EN
    ,
    .err_out      (err_out)
`endif
  );

  initial clk_100KHz = 1'b0;
  always #5 clk_100KHz = ~clk_100KHz;

  typedef struct {
    logic       dr;
    logic [7:0] din;
    logic       deq;
    logic       ack;
    logic [3:0] len;
    logic [7:0] dout;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs, clock once, leave the bench 1 time unit after the rising edge.
  task automatic cyc(input logic dr, input logic [7:0] din, input logic deq);
    data_ready_in = dr;
    data_in       = din;
    dequeue_in    = deq;
    @(posedge clk_100KHz);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    cyc(1'b1, b, 1'b0);
    chk("push_ack", 32'(ack_out), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic pop(input logic [7:0] exp);
    cyc(1'b0, 8'h00, 1'b1);
    chk("pop_data", 32'(data_out), 32'(exp));
  endtask

  initial begin
    // reset release, 0xAD held 3 cycles, then drop, then dequeue
    tbl[0] = '{dr:1'b1, din:8'hAD, deq:1'b0, ack:1'b1, len:4'd1, dout:8'h00, full:1'b0, empty:1'b0};
    tbl[1] = '{dr:1'b1, din:8'hAD, deq:1'b0, ack:1'b0, len:4'd1, dout:8'h00, full:1'b0, empty:1'b0};
    tbl[2] = '{dr:1'b1, din:8'hAD, deq:1'b0, ack:1'b0, len:4'd1, dout:8'h00, full:1'b0, empty:1'b0};
    tbl[3] = '{dr:1'b0, din:8'h00, deq:1'b0, ack:1'b0, len:4'd1, dout:8'h00, full:1'b0, empty:1'b0};
    tbl[4] = '{dr:1'b0, din:8'h00, deq:1'b1, ack:1'b0, len:4'd0, dout:8'hAD, full:1'b0, empty:1'b1};
    tbl[5] = '{dr:1'b0, din:8'h00, deq:1'b0, ack:1'b0, len:4'd0, dout:8'hAD, full:1'b0, empty:1'b1};

    reset = 1'b0;
    data_in = 8'h00;
    data_ready_in = 1'b0;
    dequeue_in = 1'b0;
    repeat (3) @(posedge clk_100KHz);
    #1;
    chk("rst_ack",   32'(ack_out),   32'd0);
    chk("rst_dout",  32'(data_out),  32'd0);
    chk("rst_len",   32'(len_out),   32'd0);
    chk("rst_full",  32'(full_out),  32'd0);
    chk("rst_empty", 32'(empty_out), 32'd1);
`ifdef FILA_ERR_EN
    chk("rst_err",   32'(err_out),   32'd0);
`endif
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].dr, tbl[i].din, tbl[i].deq);
      chk($sformatf("tbl%0d_ack", i),   32'(ack_out),   32'(tbl[i].ack));
      chk($sformatf("tbl%0d_len", i),   32'(len_out),   32'(tbl[i].len));
      chk($sformatf("tbl%0d_dout", i),  32'(data_out),  32'(tbl[i].dout));
      chk($sformatf("tbl%0d_full", i),  32'(full_out),  32'(tbl[i].full));
      chk($sformatf("tbl%0d_empty", i), 32'(empty_out), 32'(tbl[i].empty));
    end

    // fill to full, ninth byte is back-pressured
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("fill_len",  32'(len_out),  32'd8);
    chk("fill_full", 32'(full_out), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'h09, 1'b0);
      chk("full_noack", 32'(ack_out), 32'd0);
      chk("full_len",   32'(len_out), 32'd8);
    end
    cyc(1'b1, 8'h09, 1'b1);
    chk("fullpop_dout", 32'(data_out), 32'h01);
    chk("fullpop_len",  32'(len_out),  32'd7);
    chk("fullpop_ack",  32'(ack_out),  32'd0);
    cyc(1'b1, 8'h09, 1'b0);
    chk("retry_ack", 32'(ack_out), 32'd1);
    chk("retry_len", 32'(len_out), 32'd8);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    for (int i = 2; i <= 9; i++) pop(8'(i));
    chk("drain_empty", 32'(empty_out), 32'd1);

    // fill/pop again, then a short burst that crosses the pointer wrap
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    chk("fill2_full", 32'(full_out), 32'd1);
    for (int i = 0; i < 8; i++) pop(8'h20 + 8'(i));
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    chk("wrap_len", 32'(len_out), 32'd4);
    for (int i = 0; i < 4; i++) pop(8'h10 + 8'(i));
    chk("wrap_empty", 32'(empty_out), 32'd1);

    // simultaneous write and dequeue at len 3
    push(8'h31); push(8'h32); push(8'h33);
    cyc(1'b1, 8'h34, 1'b1);
    chk("simul_len",  32'(len_out),  32'd3);
    chk("simul_dout", 32'(data_out), 32'h31);
    chk("simul_ack",  32'(ack_out),  32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    pop(8'h32); pop(8'h33); pop(8'h34);

`ifdef FILA_ERR_EN
    chk("err_before", 32'(err_out), 32'd0);
`endif
    // dequeue on empty is ignored
    cyc(1'b0, 8'h00, 1'b1);
    chk("uflow_dout", 32'(data_out), 32'h34);
    chk("uflow_len",  32'(len_out),  32'd0);
`ifdef FILA_ERR_EN
    chk("uflow_err", 32'(err_out), 32'd1);
`endif
    // write and dequeue on empty: only the write lands
    cyc(1'b1, 8'h41, 1'b1);
    chk("emptysim_len",  32'(len_out),  32'd1);
    chk("emptysim_dout", 32'(data_out), 32'h34);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
`ifdef FILA_ERR_EN
    chk("err_sticky", 32'(err_out), 32'd1);
`endif
    pop(8'h41);

    // reset asserted while in ACK
    cyc(1'b1, 8'h55, 1'b0);
    chk("pre_rst_ack", 32'(ack_out), 32'd1);
    chk("pre_rst_len", 32'(len_out), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_ack",   32'(ack_out),   32'd0);
    chk("midrst_len",   32'(len_out),   32'd0);
    chk("midrst_empty", 32'(empty_out), 32'd1);
    chk("midrst_dout",  32'(data_out),  32'd0);
`ifdef FILA_ERR_EN
    chk("midrst_err",   32'(err_out),   32'd0);
`endif
    #2;
    reset = 1'b1;
    // a held data_ready is captured straight away, so the FSM came back in IDLE
    cyc(1'b1, 8'h66, 1'b0);
    chk("postrst_ack", 32'(ack_out), 32'd1);
    chk("postrst_len", 32'(len_out), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    pop(8'h66);
    chk("final_empty", 32'(empty_out), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
